// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, swap state type and sizing helpers for the paged frame buffer
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    function automatic int clog2(input longint value);
        int result;
        result = 0;
        for (longint v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int num_pages(input int double_buffer);
        return (double_buffer != 0) ? 2 : 1;
    endfunction

    function automatic int phys_w(input int depth, input int double_buffer);
        int w;
        w = clog2(longint'(num_pages(double_buffer)) * depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int num_banks(input int depth, input int double_buffer, input int bank_addr_w);
        longint words;
        longint bank_words;
        words      = longint'(num_pages(double_buffer)) * depth;
        bank_words = longint'(1) << bank_addr_w;
        return int'((words + bank_words - 1) / bank_words);
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// rtl/fb_bank_ram.sv - simple dual-port synchronous RAM bank, read-before-write
module fb_bank_ram #(
    parameter int DATA_W      = 16,
    parameter int BANK_ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [BANK_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   re,
    input  logic [BANK_ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0]      rdata
);

    logic [DATA_W-1:0] mem [2**BANK_ADDR_W];

    // Non-blocking update means a colliding read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/paged_frame_buffer.sv
// rtl/paged_frame_buffer.sv - banked pixel store with ping-pong page swap at reader-acknowledged frame boundaries
module paged_frame_buffer
    import fb_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int DEPTH         = 76800,
    parameter int ADDR_W        = 17,
    parameter int BANK_ADDR_W   = 16,
    parameter int DOUBLE_BUFFER = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_frame_end,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_frame_start,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_page,
    output logic              rd_page,
    output logic              swap_pending,
    output logic              wr_oob,
    output logic [7:0]        frame_drops
);

    localparam int PHYS_W    = phys_w(DEPTH, DOUBLE_BUFFER);
    localparam int NUM_BANKS = num_banks(DEPTH, DOUBLE_BUFFER, BANK_ADDR_W);
    localparam int SEL_W     = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [PHYS_W-1:0] PAGE_OFS = PHYS_W'(DEPTH);

    logic                   wr_in_range, rd_in_range;
    logic                   wr_ok, rd_ok;
    logic [PHYS_W-1:0]      wr_phys, rd_phys;
    logic [SEL_W-1:0]       wr_bank, rd_bank, rd_bank_q;
    logic [BANK_ADDR_W-1:0] wr_ofs, rd_ofs;
    logic                   rd_zero_q;
    logic [DATA_W-1:0]      rd_mux;
    logic [DATA_W-1:0]      bank_rdata [NUM_BANKS];

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign wr_ok       = wr_en && wr_in_range;
    assign rd_ok       = rd_en && rd_in_range;

    assign wr_phys = PHYS_W'(wr_addr) + (wr_page ? PAGE_OFS : '0);
    assign rd_phys = PHYS_W'(rd_addr) + (rd_page ? PAGE_OFS : '0);
    assign wr_bank = SEL_W'(wr_phys >> BANK_ADDR_W);
    assign rd_bank = SEL_W'(rd_phys >> BANK_ADDR_W);
    assign wr_ofs  = BANK_ADDR_W'(wr_phys);
    assign rd_ofs  = BANK_ADDR_W'(rd_phys);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        fb_bank_ram #(
            .DATA_W      (DATA_W),
            .BANK_ADDR_W (BANK_ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (wr_ok && (wr_bank == SEL_W'(b))),
            .waddr (wr_ofs),
            .wdata (wr_data),
            .re    (rd_ok && (rd_bank == SEL_W'(b))),
            .raddr (rd_ofs),
            .rdata (bank_rdata[b])
        );
    end

    // Bank select and zero flag only move on a read, so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_zero_q <= 1'b1;
            rd_bank_q <= '0;
            wr_oob    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            wr_oob   <= wr_en && !wr_in_range;
            if (rd_en) begin
                rd_zero_q <= !rd_in_range;
                rd_bank_q <= rd_bank;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank_q == SEL_W'(b)) begin
                rd_mux = bank_rdata[b];
            end
        end
    end

    assign rd_data = rd_zero_q ? '0 : rd_mux;

    swap_state_t state, state_n;
    logic        frame_end, frame_start;
    logic        do_swap, do_drop;

    assign frame_end   = (DOUBLE_BUFFER != 0) && wr_frame_end;
    assign frame_start = (DOUBLE_BUFFER != 0) && rd_frame_start;

    always_comb begin
        state_n = state;
        do_swap = 1'b0;
        do_drop = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end && frame_start) begin
                    do_swap = 1'b1;
                end else if (frame_end) begin
                    state_n = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    do_swap = 1'b1;
                    state_n = frame_end ? PENDING : IDLE;
                end else if (frame_end) begin
                    do_drop = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_page     <= 1'b0;
            rd_page     <= (DOUBLE_BUFFER != 0);
            frame_drops <= 8'd0;
        end else begin
            state <= state_n;
            if (do_swap) begin
                wr_page <= !wr_page;
                rd_page <= !rd_page;
            end
            if (do_drop && (frame_drops != 8'hFF)) begin
                frame_drops <= frame_drops + 8'd1;
            end
        end
    end

    assign swap_pending = (state == PENDING);

endmodule
